// File: rtl/dsp_seq_pkg.sv
// Shared types and constants for the DSP48A1 MAC sequencer.
package dsp_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // One issue-pipeline stage: occupancy plus "first sample of the job".
  typedef struct packed {
    logic valid;
    logic first;
  } stage_t;

  // X=M, Z=0: load the product, discarding whatever P held from a prior job.
  localparam logic [7:0] OPM_MAC_FIRST = 8'h01;
  // X=M, Z=P: accumulate onto the running sum.
  localparam logic [7:0] OPM_MAC_ACC   = 8'h09;

  // Accept -> M register -> P register -> P visible.
  localparam int unsigned DSP_LAT = 3;
  localparam int unsigned P_W     = 48;

endpackage

// File: rtl/dsp_mac_sequencer.sv
// Sequences a DSP48A1 slice (A1/B1/M/P/OPMODE registered) as a
// length-N multiply-accumulate engine fed by a valid/ready stream.
module dsp_mac_sequencer
  import dsp_seq_pkg::*;
#(
  parameter int unsigned LEN_W  = 10,
  parameter int unsigned DATA_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [P_W-1:0]    res_data,
  output logic [DATA_W-1:0] dsp_a,
  output logic [DATA_W-1:0] dsp_b,
  output logic [7:0]        dsp_opmode,
  output logic              dsp_cea,
  output logic              dsp_ceb,
  output logic              dsp_cem,
  output logic              dsp_cep,
  output logic              dsp_ceopmode,
  output logic              dsp_rst,
  input  logic [P_W-1:0]    dsp_p
);

  state_t           state;
  logic [LEN_W-1:0] remaining;
  logic             first_pend;
  stage_t           pipe [1:DSP_LAT];
  logic             accept;

  // Handshake and slice controls, all decoded from registered state.
  always_comb begin
    accept       = (state == RUN) && in_valid;
    busy         = (state != IDLE);
    in_ready     = (state == RUN);
    res_valid    = (state == DONE);
    dsp_rst      = rst;
    // Operands go straight to the A1/B1 registers in the accept cycle.
    dsp_a        = accept ? in_a : '0;
    dsp_b        = accept ? in_b : '0;
    dsp_cea      = accept;
    dsp_ceb      = accept;
    dsp_cem      = pipe[1].valid;
    dsp_ceopmode = pipe[1].valid;
    dsp_opmode   = (pipe[1].valid && pipe[1].first) ? OPM_MAC_FIRST : OPM_MAC_ACC;
    dsp_cep      = pipe[2].valid;
  end

  // Job FSM, remaining-count and issue pipeline tracking the slice registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      remaining  <= '0;
      first_pend <= 1'b0;
      res_data   <= '0;
      for (int unsigned i = 1; i <= DSP_LAT; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[1] <= '{valid: accept, first: first_pend};
      for (int unsigned i = 2; i <= DSP_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              state      <= RUN;
              remaining  <= len;
              first_pend <= 1'b1;
            end else begin
              state    <= DONE;
              res_data <= '0;
            end
          end
        end
        RUN: begin
          if (accept) begin
            remaining  <= remaining - LEN_W'(1);
            first_pend <= 1'b0;
            if (remaining == LEN_W'(1)) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // No accepts happen here, so the last sample is the one in the
          // final stage once the earlier stages have emptied.
          if (pipe[DSP_LAT].valid && !pipe[1].valid && !pipe[2].valid) begin
            res_data <= dsp_p;
            state    <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
